move_list_generator: RTL and testbench

- Sequential, parametrised successor to the combinational valid-move enumerator.
- Scans every (source, destination) square pair of a snapshotted board, one candidate per cycle.
- Queries an external combinational legality checker (move_verification) through a port pair and stores legal moves in an internal list buffer.
- Sits between the board register file and the move-selection/AI logic, which reads the list back through a registered read port.

---
 rtl/move_list_generator_if.sv | 35 +++
 rtl/move_list_generator.sv | 144 ++++++++++++++
 tb/tb_move_list_generator.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/move_list_generator_if.sv
// Bus bundle between move_list_generator and its neighbours: the board
// register file, the legality checker and the move-selection logic.
// slave  : the generator's view of the bundle.
// master : the surrounding system's view of the bundle.
interface move_list_generator_if #(
  parameter int PIECE_W = 4,
  parameter int CNT_W   = 8
);
  logic [64*PIECE_W-1:0] board;
  logic                  side;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [5:0]            chk_start;
  logic [5:0]            chk_end;
  logic [PIECE_W-1:0]    chk_piece;
  logic                  chk_valid;
  logic                  chk_legal;
  logic [CNT_W-1:0]      move_count;
  logic                  overflow;
  logic [CNT_W-1:0]      rd_addr;
  logic [11:0]           rd_data;

  modport slave (
    input  board, side, start, chk_legal, rd_addr,
    output busy, done, chk_start, chk_end, chk_piece, chk_valid,
           move_count, overflow, rd_data
  );

  modport master (
    output board, side, start, chk_legal, rd_addr,
    input  busy, done, chk_start, chk_end, chk_piece, chk_valid,
           move_count, overflow, rd_data
  );
endinterface

// File: rtl/move_list_generator.sv
// move_list_generator: sequential legal-move enumerator.
// Snapshots the board and side on start, then walks every (src, dst) square
// pair, one per cycle, asking an external combinational checker whether the
// candidate is legal. Legal moves are appended to an internal list in
// ascending scan order and read back through a registered port.
//
// Build option MOVEGEN_SRC_SKIP_EN: a source square that is empty or holds
// an opponent piece is skipped in a single cycle instead of walking its 64
// destinations. Stored list contents are identical with or without it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | out of reset, no list produced yet
// SCAN  | walking candidates, busy = 1
// DONE  | list complete and readable, done = 1
module move_list_generator #(
  parameter int MAX_MOVES = 140,
  parameter int PIECE_W   = 4,
  parameter int COLOR_BIT = 3,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  move_list_generator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

  state_t                state;
  state_t                state_nxt;
  logic [64*PIECE_W-1:0] board_q;
  logic                  side_q;
  logic [11:0]           idx;
  logic [11:0]           idx_nxt;
  logic                  scan_last;
  logic [CNT_W-1:0]      move_count;
  logic                  overflow;
  logic [11:0]           rd_data_q;
  logic [11:0]           list_mem [MAX_MOVES];

  logic [5:0]            src;
  logic [5:0]            dst;
  logic [PIECE_W-1:0]    src_piece;
  logic                  own_src;
  logic                  cand_valid;
  logic                  accept;
  logic                  hit;
  logic                  wr_en;

  assign src        = idx[11:6];
  assign dst        = idx[5:0];
  assign src_piece  = board_q[int'(src)*PIECE_W +: PIECE_W];
  assign own_src    = (src_piece != '0) && (src_piece[COLOR_BIT] == side_q);
  assign cand_valid = (state == SCAN) && own_src && (src != dst);
  // start is only honoured outside SCAN, so a running scan cannot be restarted
  assign accept     = bus.start && (state != SCAN);
  assign hit        = cand_valid && bus.chk_legal;
  assign wr_en      = hit && (move_count != MAX_CNT) && !reset;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = SCAN;
      SCAN:       if (scan_last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Scan index advance and end-of-scan detection
  always_comb begin
    idx_nxt   = idx + 12'd1;
    scan_last = (idx == 12'hFFF);
`ifdef MOVEGEN_SRC_SKIP_EN
    // Nothing to move from this square: jump straight to the next source.
    if (!own_src) begin
      idx_nxt   = {src + 6'd1, 6'd0};
      scan_last = (src == 6'd63);
    end
`endif
  end

  // Board/side snapshot; only the snapshot is consulted during SCAN
  always_ff @(posedge clk) begin
    if (accept) begin
      board_q <= bus.board;
      side_q  <= bus.side;
    end
  end

  // Scan index, move counter and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      move_count <= '0;
      overflow   <= 1'b0;
    end else if (accept) begin
      idx        <= '0;
      move_count <= '0;
      overflow   <= 1'b0;
    end else if (state == SCAN) begin
      idx <= idx_nxt;
      if (hit) begin
        if (move_count == MAX_CNT) overflow   <= 1'b1;
        else                       move_count <= move_count + CNT_W'(1);
      end
    end
  end

  // List buffer write; entries beyond move_count are never exposed
  always_ff @(posedge clk) begin
    if (wr_en) list_mem[move_count] <= {src, dst};
  end

  // Registered read port; same-cycle write is not forwarded (old contents)
  always_ff @(posedge clk) begin
    if (reset)                         rd_data_q <= '0;
    else if (bus.rd_addr < move_count) rd_data_q <= list_mem[bus.rd_addr];
    else                               rd_data_q <= '0;
  end

  assign bus.busy       = (state == SCAN);
  assign bus.done       = (state == DONE);
  assign bus.chk_start  = src;
  assign bus.chk_end    = dst;
  assign bus.chk_piece  = src_piece;
  assign bus.chk_valid  = cand_valid;
  assign bus.move_count = move_count;
  assign bus.overflow   = overflow;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_move_list_generator.sv
// Self-checking bench for move_list_generator. Table of whole-scan scenarios
// with expected counts/latencies and a table of list read-backs, followed by
// hand-written sequences for reset mid-scan and start/board changes mid-scan.
module tb_move_list_generator;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   legal_mode = 0;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  logic [3:0] piece_seen = '0;

  move_list_generator_if #(.PIECE_W(4), .CNT_W(8)) vif ();

  move_list_generator #(
    .MAX_MOVES(140), .PIECE_W(4), .COLOR_BIT(3), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  // Bench legality checker: mode 1 says everything is legal, mode 0 only
  // allows 12->20 and 12->28.
  always_comb begin
    if (legal_mode == 1) vif.chk_legal = 1'b1;
    else vif.chk_legal = (vif.chk_start == 6'd12) &&
                         ((vif.chk_end == 6'd20) || (vif.chk_end == 6'd28));
  end

  // Count presented candidates and remember the last presented piece
  always @(posedge clk) begin
    if (!reset && vif.chk_valid) begin
      valid_cnt  <= valid_cnt + 1;
      piece_seen <= vif.chk_piece;
    end
  end

  typedef struct {
    int   layout;
    logic side;
    int   legal;
    int   exp_count;
    logic exp_ovf;
    int   exp_valid;
    int   exp_piece;
    int   lat_full;
    int   lat_skip;
  } scen_t;

  typedef struct {
    int          scen;
    int          addr;
    logic [11:0] exp;
  } rd_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] layout(input int id);
    logic [255:0] b;
    b = '0;
    case (id)
      1: b[12*4 +: 4] = 4'd1;
      2: begin
        b[0*4  +: 4] = 4'd1;
        b[10*4 +: 4] = 4'd2;
        b[63*4 +: 4] = 4'd6;
        b[40*4 +: 4] = 4'd9;
      end
      3: b[20*4 +: 4] = 4'd1;
      default: b = '0;
    endcase
    return b;
  endfunction

  task automatic run_scan(output int lat);
    vif.start = 1'b1;
    @(posedge clk); #1;
    vif.start = 1'b0;
    lat = 0;
    while (!vif.done && lat < 6000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic read_check(input string name, input int addr, input logic [11:0] exp);
    vif.rd_addr = 8'(addr);
    @(posedge clk); #1;
    check(name, 32'(vif.rd_data), 32'(exp));
  endtask

  initial begin
    scen_t   scens [4];
    rd_vec_t rds   [15];
    int      lat;
    int      v0;
    int      exp_lat;
    int      rst_at;

    scens[0] = '{1, 1'b0, 0, 2,   1'b0, 63,  1, 4096, 127};
    scens[1] = '{1, 1'b1, 0, 0,   1'b0, 0,   0, 4096, 64};
    scens[2] = '{2, 1'b0, 1, 140, 1'b1, 189, 6, 4096, 253};
    scens[3] = '{2, 1'b1, 1, 63,  1'b0, 63,  9, 4096, 127};

    rds[0]  = '{0, 0,   12'h314};
    rds[1]  = '{0, 1,   12'h31C};
    rds[2]  = '{0, 2,   12'h000};
    rds[3]  = '{0, 255, 12'h000};
    rds[4]  = '{1, 0,   12'h000};
    rds[5]  = '{2, 0,   12'h001};
    rds[6]  = '{2, 62,  12'h03F};
    rds[7]  = '{2, 63,  12'h280};
    rds[8]  = '{2, 126, 12'hFC0};
    rds[9]  = '{2, 139, 12'hFCD};
    rds[10] = '{2, 140, 12'h000};
    rds[11] = '{3, 0,   12'hA00};
    rds[12] = '{3, 40,  12'hA29};
    rds[13] = '{3, 62,  12'hA3F};
    rds[14] = '{3, 63,  12'h000};

    vif.board   = '0;
    vif.side    = 1'b0;
    vif.start   = 1'b0;
    vif.rd_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy",      32'(vif.busy),       0);
    check("rst_done",      32'(vif.done),       0);
    check("rst_overflow",  32'(vif.overflow),   0);
    check("rst_chk_valid", 32'(vif.chk_valid),  0);
    check("rst_count",     32'(vif.move_count), 0);
    check("rst_chk_start", 32'(vif.chk_start),  0);
    check("rst_chk_end",   32'(vif.chk_end),    0);
    check("rst_rd_data",   32'(vif.rd_data),    0);

    for (int s = 0; s < 4; s++) begin
      vif.board  = layout(scens[s].layout);
      vif.side   = scens[s].side;
      legal_mode = scens[s].legal;
`ifdef MOVEGEN_SRC_SKIP_EN
      exp_lat = scens[s].lat_skip;
`else
      exp_lat = scens[s].lat_full;
`endif
      v0 = valid_cnt;
      run_scan(lat);
      check($sformatf("s%0d_latency", s),  32'(lat),            32'(exp_lat));
      check($sformatf("s%0d_done", s),     32'(vif.done),       1);
      check($sformatf("s%0d_busy", s),     32'(vif.busy),       0);
      check($sformatf("s%0d_count", s),    32'(vif.move_count), 32'(scens[s].exp_count));
      check($sformatf("s%0d_overflow", s), 32'(vif.overflow),   32'(scens[s].exp_ovf));
      check($sformatf("s%0d_valids", s),   32'(valid_cnt - v0), 32'(scens[s].exp_valid));
      if (scens[s].exp_valid > 0)
        check($sformatf("s%0d_piece", s),  32'(piece_seen),     32'(scens[s].exp_piece));
      for (int r = 0; r < 15; r++) begin
        if (rds[r].scen == s)
          read_check($sformatf("s%0d_rd%0d", s, rds[r].addr), rds[r].addr, rds[r].exp);
      end
    end

    // Reset in the middle of a scan discards the partial list
`ifdef MOVEGEN_SRC_SKIP_EN
    rst_at = 60;
`else
    rst_at = 2000;
`endif
    vif.board  = layout(1);
    vif.side   = 1'b0;
    legal_mode = 0;
    vif.start  = 1'b1;
    @(posedge clk); #1;
    vif.start = 1'b0;
    repeat (rst_at) @(posedge clk);
    #1;
    check("mid_busy",  32'(vif.busy),       1);
    check("mid_count", 32'(vif.move_count), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstmid_busy",     32'(vif.busy),       0);
    check("rstmid_done",     32'(vif.done),       0);
    check("rstmid_count",    32'(vif.move_count), 0);
    check("rstmid_overflow", 32'(vif.overflow),   0);
    check("rstmid_valid",    32'(vif.chk_valid),  0);
    run_scan(lat);
    check("rescan_done",  32'(vif.done),       1);
    check("rescan_count", 32'(vif.move_count), 2);
    read_check("rescan_rd0", 0, 12'h314);
    read_check("rescan_rd1", 1, 12'h31C);

    // start pulses and board edits during SCAN must not disturb the scan
    vif.board = layout(1);
    vif.side  = 1'b0;
    vif.start = 1'b1;
    @(posedge clk); #1;
    vif.start = 1'b0;
    lat = 0;
    while (!vif.done && lat < 6000) begin
      if (lat == 5)  begin vif.start = 1'b1; vif.board = layout(3); vif.side = 1'b1; end
      if (lat == 6)  vif.start = 1'b0;
      if (lat == 40) vif.start = 1'b1;
      if (lat == 41) vif.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
`ifdef MOVEGEN_SRC_SKIP_EN
    check("ign_latency", 32'(lat), 127);
`else
    check("ign_latency", 32'(lat), 4096);
`endif
    check("ign_count",    32'(vif.move_count), 2);
    check("ign_overflow", 32'(vif.overflow),   0);
    read_check("ign_rd0", 0, 12'h314);
    read_check("ign_rd1", 1, 12'h31C);
    read_check("ign_rd2", 2, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
